deframer: RTL and testbench
===========================

# deframer

Receive-side counterpart of the UART framer. Consumes the packed byte stream (one wakeup command, then repeating packets of `PacketLenElems` payload bytes, each followed by a two-byte tail) and strips the framing. It unpacks each payload byte into `PackedNum` elements of `UnpackedWidth` bits and checks tail bytes. It sits between the UART RX byte interface and the downstream pixel/magnitude consumers, and reports packet completion and framing errors.

## Interface
- `UnpackedWidth`, 1: bits per unpacked output element.
- `PackedNum`, 8: elements per packed input byte.
- `PackedWidth`, `UnpackedWidth*PackedNum`: input word width.
- `PacketLenElems`, 1024: payload words per packet; must be ≥ 2.
- `TailByte0`, 0xA5: first tail word.
- `TailByte1`, 0x5A: second tail word.
- `WakeupCmd`, 0x99: stream-start command word.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  input word valid.
- `ready_o`  out  1  input word accepted when `valid_i && ready_o`.
- `data_i`  in  `PackedWidth`  packed input word.
- `valid_o`  out  1  unpacked element valid.
- `ready_i`  in  1  downstream ready.
- `unpacked_o`  out  `UnpackedWidth`  unpacked element.
- `last_o`  out  1  qualifies the final element of a packet's payload.
- `frame_done_o`  out  1  one-cycle pulse: a packet tail was accepted and is correct.
- `frame_err_o`  out  1  one-cycle pulse: tail mismatch detected.

## Operation
- FSM states: Sync, Payload, Tail0, Tail1, Hunt. Reset state is Sync.
- **Sync:** accepts and discards words. Accepting `WakeupCmd` moves to Payload with the word counter at 0.
- **Payload:**
  - Each accepted word loads the shift buffer and increments the counter (width `$clog2(PacketLenElems)`).
  - Accepting the word with counter == `PacketLenElems-1` moves to Tail0 and clears the counter. No wrap past max.
- **Tail0:**
  - Accepted word == `TailByte0` moves to Tail1.
  - Otherwise pulse `frame_err_o` and move to Hunt.
- **Tail1:**
  - Accepted word == `TailByte1` pulses `frame_done_o` and moves to Payload.
  - Otherwise pulse `frame_err_o` and move to Hunt.
- **Hunt:**
  - `TailByte0` followed immediately by `TailByte1` moves to Payload.
  - `WakeupCmd` at any point moves to Payload.
  - No further error pulses are raised while in Hunt.
- **Unpacking:**
  - Element 0 is `data_i[UnpackedWidth-1:0]`, emitted first (LSB-first).
  - The buffer shifts right by `UnpackedWidth` on each output fire.
  - An element-remaining count tracks buffer occupancy.
- `last_o` is high with element `PackedNum-1` of the final payload word of a packet.
- **`ready_o`:**
  - In Payload: buffer empty, or buffer emitting its last element this cycle.
  - In Tail0/Tail1: buffer empty, so `frame_done_o` never precedes the final element.
  - In Sync/Hunt: 1.
  - Forced to 0 while `rst_i` is asserted.
- Non-payload words never produce output elements.

## Timing
- Reset values: `valid_o`=0, `unpacked_o`=0, `last_o`=0, `frame_done_o`=0, `frame_err_o`=0, `ready_o`=0. The counter, buffer and state clear asynchronously.
- Latency: a payload word accepted at cycle t presents element 0 at t+1. Elements follow one per cycle while `ready_i`=1.
- Sustained throughput: one element per cycle. A new payload word is accepted in the same cycle the previous word's last element fires (no bubble).
- `valid_o`, `unpacked_o` and `last_o` are held stable while `valid_o && !ready_i`.
- `frame_done_o` and `frame_err_o` are registered: they assert the cycle after the tail word is accepted, for exactly one cycle.
- Reset mid-packet discards the buffer. The block returns to Sync and requires a new `WakeupCmd`.
- A repeated `WakeupCmd` inside Payload is treated as data, not as a restart.

## Configuration
- `DEFRAMER_TAIL_CHECK_EN` defined:
  - Tail words are compared as above.
  - Mismatch raises `frame_err_o` and enters Hunt.
- Not defined:
  - Tail0/Tail1 accept and discard any word.
  - `frame_done_o` pulses after every second tail word.
  - Hunt is unreachable and `frame_err_o` is tied to 0.

## Test plan
All scenarios use UnpackedWidth=2, PackedNum=4, PacketLenElems=4, macro defined unless noted.
- **Basic packet:** send 0x99, 0xE4, 0x1B, 0xFF, 0x00, 0xA5, 0x5A with `ready_i`=1.
  - Elements 0,1,2,3, 3,2,1,0, 3,3,3,3, 0,0,0,0.
  - `last_o` on the 16th element only; `frame_done_o` pulses once, after it.
- **Backpressure:** as the basic packet, with `ready_i` toggling 1/0 every cycle.
  - Identical element sequence; outputs stable during stalls.
  - `ready_o` low while the buffer holds ≥2 elements.
- **Pre-wakeup garbage:** send 0x12, 0xA5, 0x99, then the basic payload.
  - No elements before 0x99; the packet decodes exactly.
- **Bad tail:** send 0x99, four payload words, 0xA5, 0x00.
  - `frame_err_o` pulses once, no `frame_done_o`.
  - Then 0x33, 0xA5, 0x5A, four payload words decode normally.
- **Reset mid-payload:** assert `rst_i` after two payload words.
  - All outputs 0 immediately.
  - After release, payload words before a new 0x99 produce no output.
- **Macro undefined:** tail 0x00, 0x00.
  - `frame_done_o` pulses, `frame_err_o` stays 0, the next packet decodes.

Source files
------------

// File: rtl/deframer_if.sv
// Byte-in / element-out handshake bundle of the deframer.
// slave: the deframer itself; master: the upstream/downstream environment.
interface deframer_if #(
    parameter int UnpackedWidth = 1,
    parameter int PackedNum     = 8
);
    localparam int PackedWidth = UnpackedWidth * PackedNum;

    logic                     valid_i;
    logic                     ready_o;
    logic [PackedWidth-1:0]   data_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [UnpackedWidth-1:0] unpacked_o;
    logic                     last_o;
    logic                     frame_done_o;
    logic                     frame_err_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, unpacked_o, last_o, frame_done_o, frame_err_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, unpacked_o, last_o, frame_done_o, frame_err_o
    );
endinterface

// File: rtl/deframer.sv
// Deframer: strips wakeup/tail framing from a packed byte stream and unpacks payload LSB-first.
// Define DEFRAMER_TAIL_CHECK_EN to enable tail-word checking with Hunt recovery.
module deframer #(
    parameter int UnpackedWidth  = 1,
    parameter int PackedNum      = 8,
    parameter int PackedWidth    = UnpackedWidth * PackedNum,
    parameter int PacketLenElems = 1024,
    parameter int TailByte0      = 'hA5,
    parameter int TailByte1      = 'h5A,
    parameter int WakeupCmd      = 'h99
) (
    input  logic      clk_i,
    input  logic      rst_i,
    deframer_if.slave bus
);

`ifdef DEFRAMER_TAIL_CHECK_EN
    localparam bit TailCheck = 1'b1;
`else
    localparam bit TailCheck = 1'b0;
`endif

    localparam int CntW = $clog2(PacketLenElems);
    localparam int RemW = $clog2(PackedNum + 1);

    localparam logic [CntW-1:0]        CntMax  = CntW'(PacketLenElems - 1);
    localparam logic [RemW-1:0]        RemFull = RemW'(PackedNum);
    localparam logic [RemW-1:0]        RemOne  = RemW'(1);
    localparam logic [PackedWidth-1:0] Tail0W  = PackedWidth'(TailByte0);
    localparam logic [PackedWidth-1:0] Tail1W  = PackedWidth'(TailByte1);
    localparam logic [PackedWidth-1:0] WakeW   = PackedWidth'(WakeupCmd);

    typedef enum logic [2:0] {SYNC, PAYLOAD, TAIL0, TAIL1, HUNT} state_t;

    state_t                 state_q, state_nxt;
    logic [CntW-1:0]        cnt_q, cnt_nxt;
    logic                   hunt_a5_q, hunt_a5_nxt;
    logic                   done_q, done_nxt;
    logic                   err_q, err_nxt;
    logic                   load;
    logic [PackedWidth-1:0] shift_buf_q;
    logic [RemW-1:0]        rem_q;
    logic                   last_word_q;
    logic                   buf_empty;
    logic                   fire;
    logic                   ready;
    logic                   accept;

    assign buf_empty = (rem_q == '0);
    assign fire      = !buf_empty && bus.ready_i;
    assign accept    = bus.valid_i && ready;

    // A payload word may replace the buffer in the cycle its last element leaves;
    // tail words wait for a fully drained buffer so completion never overtakes data.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            SYNC, HUNT:   ready = 1'b1;
            PAYLOAD:      ready = buf_empty || ((rem_q == RemOne) && fire);
            TAIL0, TAIL1: ready = buf_empty;
            default:      ready = 1'b0;
        endcase
        if (rst_i) ready = 1'b0;
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        hunt_a5_nxt = hunt_a5_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        load        = 1'b0;
        if (accept) begin
            case (state_q)
                SYNC: begin
                    if (bus.data_i == WakeW) begin
                        state_nxt = PAYLOAD;
                        cnt_nxt   = '0;
                    end
                end
                PAYLOAD: begin
                    load = 1'b1;
                    if (cnt_q == CntMax) begin
                        state_nxt = TAIL0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CntW'(1);
                    end
                end
                TAIL0: begin
                    if (!TailCheck || bus.data_i == Tail0W) begin
                        state_nxt = TAIL1;
                    end else begin
                        err_nxt     = 1'b1;
                        hunt_a5_nxt = 1'b0;
                        state_nxt   = HUNT;
                    end
                end
                TAIL1: begin
                    if (!TailCheck || bus.data_i == Tail1W) begin
                        done_nxt  = 1'b1;
                        state_nxt = PAYLOAD;
                    end else begin
                        err_nxt     = 1'b1;
                        hunt_a5_nxt = 1'b0;
                        state_nxt   = HUNT;
                    end
                end
                HUNT: begin
                    hunt_a5_nxt = (bus.data_i == Tail0W);
                    if (bus.data_i == WakeW || (hunt_a5_q && bus.data_i == Tail1W)) begin
                        state_nxt = PAYLOAD;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SYNC;
            cnt_q     <= '0;
            hunt_a5_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            hunt_a5_q <= hunt_a5_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_buf_q <= '0;
            rem_q       <= '0;
            last_word_q <= 1'b0;
        end else if (load) begin
            shift_buf_q <= bus.data_i;
            rem_q       <= RemFull;
            last_word_q <= (cnt_q == CntMax);
        end else if (fire) begin
            shift_buf_q <= shift_buf_q >> UnpackedWidth;
            rem_q       <= rem_q - RemOne;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.valid_o      = !buf_empty;
    assign bus.unpacked_o   = shift_buf_q[UnpackedWidth-1:0];
    assign bus.last_o       = last_word_q && (rem_q == RemOne);
    assign bus.frame_done_o = done_q;
    assign bus.frame_err_o  = TailCheck && err_q;

endmodule

// File: tb/tb_deframer.sv
// Scoreboard bench for deframer: a word-level stream parser predicts elements and
// done/err pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_deframer;
    localparam int UW = 2;
    localparam int PN = 4;
    localparam int PL = 4;

`ifdef DEFRAMER_TAIL_CHECK_EN
    localparam bit TAIL_CHECK = 1'b1;
`else
    localparam bit TAIL_CHECK = 1'b0;
`endif

    typedef struct {
        int kind;   // 0 element, 1 frame_done, 2 frame_err
        int val;
        int lst;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 0;
    tok_t exp_q[$];
    int   got_log[$];

    int   m_mode = 0;
    int   m_pos = 0;
    bit   m_a5 = 1'b0;

    bit         prev_stall = 1'b0;
    logic [1:0] prev_u;
    logic       prev_l;

    deframer_if #(.UnpackedWidth(UW), .PackedNum(PN)) bus ();

    deframer #(
        .UnpackedWidth (UW),
        .PackedNum     (PN),
        .PacketLenElems(PL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic push_tok(input int kind, input int val, input int lst);
        tok_t t;
        t.kind = kind;
        t.val  = val;
        t.lst  = lst;
        exp_q.push_back(t);
    endtask

    task automatic expect_tok(input int kind, input int val, input int lst, input string name);
        tok_t t;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected output kind %0d value %0d, scoreboard empty (t=%0t)",
                     name, kind, val, $time);
        end else begin
            t = exp_q.pop_front();
            check({name, "_kind"}, kind, t.kind);
            if (kind == 0 && t.kind == 0) begin
                check("elem_value", val, t.val);
                check("elem_last", lst, t.lst);
            end
        end
    endtask

    task automatic enter_hunt();
        push_tok(2, 0, 0);
        m_mode = 2;
        m_a5   = 1'b0;
    endtask

    // Word-level reference: what each accepted byte means for the stream.
    task automatic model_word(input logic [7:0] w);
        int pend;
        case (m_mode)
            0: if (w == 8'h99) begin m_mode = 1; m_pos = 0; end
            1: begin
                if (m_pos < PL) begin
                    pend = 0;
                    foreach (exp_q[k]) if (exp_q[k].kind == 0) pend++;
                    check("ready_early", pend, 0);
                    for (int i = 0; i < PN; i++)
                        push_tok(0, int'((w >> (i * UW)) & 8'h3),
                                 int'(m_pos == PL - 1 && i == PN - 1));
                    m_pos++;
                end else if (m_pos == PL) begin
                    if (TAIL_CHECK && w != 8'hA5) enter_hunt();
                    else m_pos++;
                end else begin
                    if (TAIL_CHECK && w != 8'h5A) enter_hunt();
                    else begin push_tok(1, 0, 0); m_pos = 0; end
                end
            end
            default: begin
                if (w == 8'h99 || (m_a5 && w == 8'h5A)) begin m_mode = 1; m_pos = 0; end
                m_a5 = (w == 8'hA5);
            end
        endcase
    endtask

    always @(posedge clk) if (bus.valid_i && bus.ready_o) acc_cnt++;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.ready_i = 1'b1;
            1:       bus.ready_i = !bus.ready_i;
            default: bus.ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(bus.valid_o), 1);
                check("stall_value", int'(bus.unpacked_o), int'(prev_u));
                check("stall_last", int'(bus.last_o), int'(prev_l));
            end
            if (bus.frame_done_o) expect_tok(1, 0, 0, "done");
            if (bus.frame_err_o) expect_tok(2, 0, 0, "err");
            if (bus.valid_o && bus.ready_i) begin
                expect_tok(0, int'(bus.unpacked_o), int'(bus.last_o), "elem");
                got_log.push_back(int'(bus.unpacked_o));
            end
            prev_stall = bus.valid_o && !bus.ready_i;
            prev_u     = bus.unpacked_o;
            prev_l     = bus.last_o;
        end
    end

    task automatic send(input logic [7:0] w);
        int n;
        int cyc;
        n = acc_cnt;
        cyc = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = w;
        while (acc_cnt == n && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.valid_i = 1'b0;
        if (acc_cnt == n) check("accept_timeout", 0, 1);
        else model_word(w);
    endtask

    task automatic send_packet(input logic [31:0] pay, input logic [7:0] t0, input logic [7:0] t1);
        for (int i = 0; i < PL; i++) send(pay[8*i +: 8]);
        send(t0);
        send(t1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_unpacked_o", int'(bus.unpacked_o), 0);
        check("rst_last_o", int'(bus.last_o), 0);
        check("rst_frame_done_o", int'(bus.frame_done_o), 0);
        check("rst_frame_err_o", int'(bus.frame_err_o), 0);
        check("rst_ready_o", int'(bus.ready_o), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_mode = 0;
        m_pos  = 0;
        m_a5   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic check_basic_log(input string name);
        int golden[16] = '{0, 1, 2, 3, 3, 2, 1, 0, 3, 3, 3, 3, 0, 0, 0, 0};
        check({name, "_count"}, got_log.size(), 16);
        for (int i = 0; i < 16 && i < got_log.size(); i++)
            check({name, "_elem"}, got_log[i], golden[i]);
    endtask

    localparam logic [31:0] BASIC = 32'h00FF1BE4;  // bytes E4,1B,FF,00 in send order

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #2 rst = 1'b0;

        // Basic packet, always ready
        rdy_mode = 0;
        got_log.delete();
        send(8'h99);
        send_packet(BASIC, 8'hA5, 8'h5A);
        drain();
        check_basic_log("basic");
        do_reset();

        // Backpressure
        rdy_mode = 1;
        got_log.delete();
        send(8'h99);
        send_packet(BASIC, 8'hA5, 8'h5A);
        drain();
        check_basic_log("bp");
        do_reset();

        // Garbage before wakeup
        rdy_mode = 0;
        got_log.delete();
        send(8'h12);
        send(8'hA5);
        send(8'h99);
        send_packet(BASIC, 8'hA5, 8'h5A);
        drain();
        check_basic_log("garbage");
        do_reset();

        // Bad tail then resynchronisation
        send(8'h99);
        send_packet(BASIC, 8'hA5, 8'h00);
        send(8'h33);
        send(8'hA5);
        send(8'h5A);
        send_packet(BASIC, 8'hA5, 8'h5A);
        drain();
        do_reset();

        // Zero tail followed by another packet
        send(8'h99);
        send_packet(BASIC, 8'h00, 8'h00);
        send_packet(BASIC, 8'hA5, 8'h5A);
        send_packet(32'h12345678, 8'hA5, 8'h5A);
        drain();
        do_reset();

        // Reset in the middle of a payload
        rdy_mode = 1;
        send(8'h99);
        send(8'hE4);
        send(8'h1B);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_mode = 0;
        m_pos  = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'hE4);
        repeat (10) @(posedge clk);
        #1;
        send(8'h99);
        send_packet(BASIC, 8'hA5, 8'h5A);
        drain();
        do_reset();

        // Randomized streams with random backpressure
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            send(8'h99);
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 9))
                    0: send(8'($urandom_range(0, 255)));
                    1: send(8'h99);
                    2: send_packet($urandom, 8'($urandom_range(0, 255)), 8'h5A);
                    3: send_packet($urandom, 8'hA5, 8'($urandom_range(0, 255)));
                    default: send_packet($urandom, 8'hA5, 8'h5A);
                endcase
            end
            drain();
            do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end
endmodule
